systolic_array_sequencer: RTL and testbench

//  Sequencer for the MATRIX_SIZE x MATRIX_SIZE systolic matrix_multiply array.
//  - Holds operand matrices A and B in internal row buffers, loaded over a row-write port.
//  - On start: clears the array accumulators, then streams skewed A rows and B columns into the array edges.
//  - After draining, captures the product into a result register and pulses done.

---
 rtl/systolic_array_sequencer.sv | 155 +++++++++++++++
 tb/tb_systolic_array_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_sequencer.sv
// Loads A/B operand rows, clears the external systolic array, streams skewed rows/columns into it,
// then captures the accumulators into result and pulses done (3N+DRAIN_CYCLES edges after start).
module systolic_array_sequencer #(
  parameter int MATRIX_SIZE  = 4,
  parameter int DATA_SIZE    = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            load_en,
  input  logic                                            load_sel,
  input  logic [$clog2(MATRIX_SIZE)-1:0]                  load_row,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]           load_data,
  output logic                                            load_err,
  input  logic                                            start,
  output logic                                            busy,
  output logic                                            arr_reset,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]           arr_in_a,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]           arr_in_b,
  input  logic [MATRIX_SIZE*MATRIX_SIZE-1:0][DATA_SIZE-1:0] arr_out,
  output logic [MATRIX_SIZE*MATRIX_SIZE-1:0][DATA_SIZE-1:0] result,
  output logic                                            done
);

  localparam int N        = MATRIX_SIZE;
  localparam int FEED_MAX = 3 * N - 3;
  localparam int CNT_MAX  = (FEED_MAX > DRAIN_CYCLES) ? FEED_MAX : DRAIN_CYCLES;
  localparam int CW       = $clog2(CNT_MAX + 2);
  localparam logic [CW-1:0] FEED_LAST  = CW'(FEED_MAX);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
  localparam bit ROW_POW2 = ((1 << $clog2(N)) == N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] feed_t;
  logic [N-1:0][N-1:0][DATA_SIZE-1:0] buf_a;
  logic [N-1:0][N-1:0][DATA_SIZE-1:0] buf_b;
  logic [N-1:0][DATA_SIZE-1:0] feed_a_nxt;
  logic [N-1:0][DATA_SIZE-1:0] feed_b_nxt;
  logic load_ok;
  logic row_ok;
  logic load_wr;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_CLEAR;
      S_CLEAR:   state_nxt = S_FEED;
      S_FEED:    if (cnt == FEED_LAST) state_nxt = S_DRAIN;
      S_DRAIN:   if (cnt == '0) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state != S_IDLE) && (state != S_DONE);
    done      = (state == S_DONE);
    arr_reset = reset || (state == S_CLEAR);
  end

  // cnt is the feed slot t in FEED and a down-counter in DRAIN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case (state)
        S_FEED:  cnt <= (cnt == FEED_LAST) ? DRAIN_LAST : cnt + 1'b1;
        S_DRAIN: cnt <= (cnt == '0) ? '0 : cnt - 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  // Feeds are computed for the slot being entered so they are valid in that slot's cycle
  always_comb begin
    feed_t     = (state == S_CLEAR) ? '0 : cnt + 1'b1;
    feed_a_nxt = '0;
    feed_b_nxt = '0;
    if (state_nxt == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(feed_t) == i + k) begin
            feed_a_nxt[i] = buf_a[i][k];
            feed_b_nxt[i] = buf_b[k][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arr_in_a <= '0;
      arr_in_b <= '0;
    end else begin
      arr_in_a <= feed_a_nxt;
      arr_in_b <= feed_b_nxt;
    end
  end

  // Operand row writes, accepted only while the array is not being driven
  always_comb begin
    load_ok = (state == S_IDLE) || (state == S_DONE);
    row_ok  = ROW_POW2 || (int'(load_row) < N);
    load_wr = load_en && load_ok && row_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_a    <= '0;
      buf_b    <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= load_en && !(load_ok && row_ok);
      if (load_wr) begin
        if (load_sel) begin
          buf_b[load_row] <= load_data;
        end else begin
          buf_a[load_row] <= load_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
    end else if (state == S_CAPTURE) begin
      result <= arr_out;
    end
  end

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Directed bench for systolic_array_sequencer with a behavioural output-stationary PE array
// closing the loop between arr_in_a/arr_in_b and arr_out.
module tb_systolic_array_sequencer;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int DC = 2;
  localparam int RB = N * N * W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_en = 1'b0;
  logic load_sel = 1'b0;
  logic [1:0] load_row = '0;
  logic [N-1:0][W-1:0] load_data = '0;
  logic load_err;
  logic start = 1'b0;
  logic busy;
  logic arr_reset;
  logic [N-1:0][W-1:0] arr_in_a;
  logic [N-1:0][W-1:0] arr_in_b;
  logic [N*N-1:0][W-1:0] arr_out;
  logic [N*N-1:0][W-1:0] result;
  logic done;

  int errors = 0;
  int checks = 0;
  int ma[N][N];
  int mb[N][N];

  always #5 clk = ~clk;

  systolic_array_sequencer #(
    .MATRIX_SIZE(N),
    .DATA_SIZE(W),
    .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load_en(load_en),
    .load_sel(load_sel),
    .load_row(load_row),
    .load_data(load_data),
    .load_err(load_err),
    .start(start),
    .busy(busy),
    .arr_reset(arr_reset),
    .arr_in_a(arr_in_a),
    .arr_in_b(arr_in_b),
    .arr_out(arr_out),
    .result(result),
    .done(done)
  );

  // Behavioural systolic array: a moves east, b moves south, each PE accumulates a*b
  logic [W-1:0] pa[N][N];
  logic [W-1:0] pb[N][N];
  logic [W-1:0] acc[N][N];

  function automatic logic [W-1:0] a_at(int i, int j);
    return (j == 0) ? arr_in_a[i] : pa[i][j-1];
  endfunction

  function automatic logic [W-1:0] b_at(int i, int j);
    return (i == 0) ? arr_in_b[j] : pb[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (arr_reset) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          pa[i][j]  <= a_at(i, j);
          pb[i][j]  <= b_at(i, j);
          acc[i][j] <= acc[i][j] + a_at(i, j) * b_at(i, j);
        end
      end
    end
  end

  always_comb begin
    arr_out = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        arr_out[i*N+j] = acc[i][j];
  end

  task automatic chk(input string tag, input logic [RB-1:0] got, input logic [RB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0][W-1:0] exp_feed_a(int t);
    logic [N-1:0][W-1:0] v = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) v[i] = W'(ma[i][t-i]);
    return v;
  endfunction

  function automatic logic [N-1:0][W-1:0] exp_feed_b(int t);
    logic [N-1:0][W-1:0] v = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) v[j] = W'(mb[t-j][j]);
    return v;
  endfunction

  function automatic logic [RB-1:0] matmul();
    logic [N*N-1:0][W-1:0] c = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s = 0;
        for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
        c[i*N+j] = W'(s);
      end
    return c;
  endfunction

  task automatic load_one(input logic sel, input int row);
    load_en  = 1'b1;
    load_sel = sel;
    load_row = 2'(row);
    for (int k = 0; k < N; k++)
      load_data[k] = sel ? W'(mb[row][k]) : W'(ma[row][k]);
  endtask

  task automatic load_mats;
    for (int r = 0; r < N; r++) begin
      load_one(1'b0, r);
      tick;
    end
    for (int r = 0; r < N; r++) begin
      load_one(1'b1, r);
      tick;
    end
    load_en = 1'b0;
  endtask

  // Caller sets start (and optionally a load) before calling; returns in the DONE cycle
  task automatic run_mult(input int poke, input bit chk_skew, input logic [RB-1:0] exp_res);
    int  e;
    bit  seen;
    tick;
    start   = 1'b0;
    load_en = 1'b0;
    chk("clear_arr_reset", RB'(arr_reset), RB'(1));
    chk("clear_busy", RB'(busy), RB'(1));
    e    = 0;
    seen = 0;
    while (!seen && e < 40) begin
      if (poke >= 0 && e == poke) begin
        start     = 1'b1;
        load_en   = 1'b1;
        load_sel  = 1'b0;
        load_row  = 2'd0;
        load_data = '1;
      end
      tick;
      e++;
      if (poke >= 0 && e == poke + 1) begin
        start   = 1'b0;
        load_en = 1'b0;
        chk("busy_load_err", RB'(load_err), RB'(1));
      end
      if (poke >= 0 && e == poke + 2)
        chk("load_err_once", RB'(load_err), RB'(0));
      if (chk_skew && e >= 1 && e <= 3 * N - 2)
        chk($sformatf("skew_t%0d", e - 1), RB'({arr_in_a, arr_in_b}),
            RB'({exp_feed_a(e - 1), exp_feed_b(e - 1)}));
      if (e == 3 * N - 1)
        chk("drain_feeds_zero", RB'({arr_in_a, arr_in_b}), RB'(0));
      if (done) seen = 1;
      else chk($sformatf("busy_e%0d", e), RB'(busy), RB'(1));
    end
    chk("done_latency", RB'(e), RB'(14));
    chk("result", result, exp_res);
    chk("busy_in_done", RB'(busy), RB'(0));
  endtask

  initial begin
    logic [N*N-1:0][W-1:0] exp2;
    bit seen_done;

    tick;
    tick;
    chk("rst_busy", RB'(busy), RB'(0));
    chk("rst_done", RB'(done), RB'(0));
    chk("rst_load_err", RB'(load_err), RB'(0));
    chk("rst_arr_reset", RB'(arr_reset), RB'(1));
    chk("rst_feeds", RB'({arr_in_a, arr_in_b}), RB'(0));
    chk("rst_result", result, '0);
    reset = 1'b0;
    tick;
    chk("idle_arr_reset", RB'(arr_reset), RB'(0));

    // 1: identity times 1..16 gives B back
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = i * N + j + 1;
      end
    load_mats;
    chk("load_err_idle", RB'(load_err), RB'(0));
    start = 1'b1;
    run_mult(-1, 1'b0, 128'h100f0e0d_0c0b0a09_08070605_04030201);
    tick;

    // 2: rank-one operands, skew checked every feed slot
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = i + 1;
        mb[i][j] = j + 1;
      end
    exp2 = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp2[i*N+j] = W'(4 * (i + 1) * (j + 1));
    load_mats;
    start = 1'b1;
    run_mult(-1, 1'b1, exp2);
    tick;

    // 3: all 0xFF wraps to 0x04 per element
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 255;
        mb[i][j] = 255;
      end
    load_mats;
    start = 1'b1;
    run_mult(-1, 1'b0, {16{8'h04}});
    chk("result_holds", result, {16{8'h04}});
    tick;
    chk("result_holds_idle", result, {16{8'h04}});

    // 4: reset during FEED t=5
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (6) tick;
    chk("mid_busy", RB'(busy), RB'(1));
    reset = 1'b1;
    #1;
    chk("mid_arr_reset", RB'(arr_reset), RB'(1));
    tick;
    reset = 1'b0;
    chk("mid_rst_busy", RB'(busy), RB'(0));
    chk("mid_rst_done", RB'(done), RB'(0));
    chk("mid_rst_feeds", RB'({arr_in_a, arr_in_b}), RB'(0));
    chk("mid_rst_result", result, '0);
    seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (done) seen_done = 1;
    end
    chk("no_done_after_reset", RB'(seen_done), RB'(0));

    // 5: start and load during FEED are ignored, load_err pulses once
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = i + 1;
        mb[i][j] = j + 1;
      end
    load_mats;
    start = 1'b1;
    run_mult(4, 1'b0, exp2);

    // 6: load in DONE, load+start in the following IDLE cycle
    for (int k = 0; k < N; k++) begin
      ma[0][k] = k + 1;
      ma[1][k] = k + 5;
    end
    load_one(1'b0, 0);
    tick;
    chk("done_load_err", RB'(load_err), RB'(0));
    load_one(1'b0, 1);
    start = 1'b1;
    run_mult(-1, 1'b0, matmul());
    chk("b2b_load_err", RB'(load_err), RB'(0));
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
